fetch_ctrl: RTL
===============

// Module: fetch_ctrl
// PURPOSE
//  Next-PC sequencer for the IF stage. Every cycle it selects the PC that the IF-stage PC register
//  loads next: sequential, hold, jump, branch, trap vector or boot address. It also raises pipeline
//  flushes and counts redirects. Sits between the hazard/EX/ID control signals and the IF-stage
//  pc_if_i input; the IF stage's pc_if_o feeds back to pc_cur.
// PARAMETERS
//  RESET_PC     32'h0000_0000  boot fetch address
//  TRAP_VEC     32'h0000_0100  target on trap or misaligned redirect
//  BOOT_CYCLES  4              cycles held in BOOT after reset release (>=1)
//  CNT_W        16             width of redirect_cnt
// PORTS
//  clk           in   1      system clock, all state on rising edge
//  rst_n         in   1      asynchronous active-low reset
//  pc_cur        in   32     current PC from IF stage
//  stall         in   1      hazard unit: hold PC
//  halt_req      in   1      enter HALT after current cycle
//  resume        in   1      leave HALT
//  jump_valid    in   1      ID-stage jump (jal)
//  jump_target   in   32
//  br_taken      in   1      EX-stage resolved taken branch/jalr
//  br_target     in   32
//  trap          in   1      exception/ecall request
//  pc_next       out  32     value IF PC register loads (drives pc_if_i)
//  fetch_valid   out  1      IF output is a real instruction this cycle
//  if_flush      out  1      kill IF/ID register content
//  id_flush      out  1      kill ID/EX register content
//  misalign_err  out  1      registered 1-cycle pulse: redirect target[1:0]!=0
//  halted        out  1      state==HALT
//  redirect_cnt  out  CNT_W  saturating count of applied redirects
// BEHAVIOUR
//  Reset (async, rst_n=0): state=BOOT, boot counter=0, redirect_cnt=0, misalign_err=0.
//   pc_next=RESET_PC, fetch_valid=0, if_flush=id_flush=0, halted=0.
//  FSM states: BOOT, RUN, HALT.
//  - BOOT: pc_next=RESET_PC, fetch_valid=0, all requests ignored. Counter increments each cycle.
//    At count==BOOT_CYCLES-1 go to RUN. First RUN cycle fetches RESET_PC.
//  - RUN: fetch_valid=~stall. pc_next is chosen by fixed priority, decided combinationally the
//    same cycle:
//    1 trap                -> TRAP_VEC; if_flush=1, id_flush=1
//    2 br_taken            -> br_target; if_flush=1, id_flush=1
//    3 jump_valid & ~stall -> jump_target; if_flush=1, id_flush=0
//    4 stall               -> pc_cur; no flush
//    5 else                -> pc_cur+32'd4 (mod 2^32: 32'hFFFF_FFFC wraps to 0)
//  - trap and br_taken override stall. jump_valid is ignored while stall=1; ID holds and re-asserts it.
//  - Misaligned target (priority 2/3 selected, target[1:0]!=0): pc_next=TRAP_VEC, both flushes=1.
//    misalign_err=1 on the following cycle only.
//  - redirect_cnt +1 per cycle where priority 1-3 applies. It saturates at all-ones; no wrap.
//  - halt_req in RUN: the current cycle is processed normally, then next state=HALT.
//    A redirect in the same cycle is still applied.
//  - HALT: pc_next=pc_cur, fetch_valid=0, flushes=0, halted=1.
//    trap -> RUN with the trap redirect applied that cycle.
//    resume -> RUN next cycle. halt_req and resume together in HALT: stay in HALT.
//  - Reset assertion mid-operation returns to BOOT immediately. No pending state survives.
// STRUCTURE
//  Shared package: state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2) and 3-bit next-PC select codes
//  (SEL_SEQ, SEL_HOLD, SEL_JMP, SEL_BR, SEL_TRAP, SEL_BOOT).
//  One sub-module, npc_mux: purely combinational priority select plus adder, driven by the FSM.
//  FSM, boot counter, misalign_err flop and redirect counter stay in fetch_ctrl.
// TESTING
//  1 Reset with BOOT_CYCLES=4: pc_next=0 and fetch_valid=0 for 4 cycles, then 0,4,8,C on pc_cur feedback.
//  2 pc_cur=0x20, stall=1, jump_valid=1 jump_target=0x80 -> pc_next=0x20, no flush.
//    Drop stall -> pc_next=0x80, if_flush=1, id_flush=0.
//  3 Same cycle: br_taken br_target=0x40, jump_valid 0x80, stall=1 -> pc_next=0x40, both flushes,
//    redirect_cnt +1.
//  4 br_target=0x42 -> pc_next=TRAP_VEC=0x100, both flushes; misalign_err=1 the next cycle only.
//  5 halt_req in RUN -> halted=1 and pc_next=pc_cur next cycle. resume -> RUN, pc_cur+4.
//    trap while halted -> pc_next=0x100.
//  6 CNT_W=2, 5 back-to-back branches -> redirect_cnt 1,2,3,3,3. pc_cur=0xFFFF_FFFC -> pc_next=0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the IF-stage next-PC sequencer: FSM states and next-PC select codes.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef enum logic [2:0] {
        SEL_SEQ  = 3'd0,
        SEL_HOLD = 3'd1,
        SEL_JMP  = 3'd2,
        SEL_BR   = 3'd3,
        SEL_TRAP = 3'd4,
        SEL_BOOT = 3'd5
    } npc_sel_t;

    function automatic logic is_redirect(input npc_sel_t sel);
        return (sel == SEL_TRAP) || (sel == SEL_BR) || (sel == SEL_JMP);
    endfunction

endpackage

// File: rtl/fetch_ctrl_npc_mux.sv
// Combinational next-PC priority select, sequential adder and flush/misalign decode.
module npc_mux
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  fetch_state_t state,
    input  logic [31:0]  pc_cur,
    input  logic         stall,
    input  logic         jump_valid,
    input  logic [31:0]  jump_target,
    input  logic         br_taken,
    input  logic [31:0]  br_target,
    input  logic         trap,
    output logic [31:0]  pc_next,
    output logic         if_flush,
    output logic         id_flush,
    output logic         redirect,
    output logic         misalign
);

    npc_sel_t sel;

    always_comb begin
        sel = SEL_BOOT;
        unique case (state)
            BOOT: sel = SEL_BOOT;
            HALT: sel = trap ? SEL_TRAP : SEL_HOLD;
            RUN: begin
                if (trap)                     sel = SEL_TRAP;
                else if (br_taken)            sel = SEL_BR;
                else if (jump_valid && !stall) sel = SEL_JMP;
                else if (stall)               sel = SEL_HOLD;
                else                          sel = SEL_SEQ;
            end
            default: sel = SEL_BOOT;
        endcase
    end

    always_comb begin
        misalign = ((sel == SEL_BR)  && (br_target[1:0]   != 2'b00)) ||
                   ((sel == SEL_JMP) && (jump_target[1:0] != 2'b00));
        redirect = is_redirect(sel);

        pc_next = RESET_PC;
        unique case (sel)
            SEL_SEQ:  pc_next = pc_cur + 32'd4;
            SEL_HOLD: pc_next = pc_cur;
            SEL_JMP:  pc_next = jump_target;
            SEL_BR:   pc_next = br_target;
            SEL_TRAP: pc_next = TRAP_VEC;
            SEL_BOOT: pc_next = RESET_PC;
            default:  pc_next = RESET_PC;
        endcase
        // A misaligned redirect is diverted to the trap vector and flushes like a trap.
        if (misalign) pc_next = TRAP_VEC;

        if_flush = redirect;
        id_flush = (sel == SEL_TRAP) || (sel == SEL_BR) || misalign;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage next-PC sequencer: BOOT/RUN/HALT FSM, boot delay, misalign pulse and redirect counter.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
    parameter int unsigned BOOT_CYCLES = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      pc_cur,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             jump_valid,
    input  logic [31:0]      jump_target,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             trap,
    output logic [31:0]      pc_next,
    output logic             fetch_valid,
    output logic             if_flush,
    output logic             id_flush,
    output logic             misalign_err,
    output logic             halted,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam int unsigned BCW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [BCW-1:0] BOOT_LAST = BCW'(BOOT_CYCLES - 1);

    fetch_state_t   state, state_nxt;
    logic [BCW-1:0] boot_cnt;
    logic           redirect;
    logic           misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= BOOT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            BOOT: if (boot_cnt == BOOT_LAST) state_nxt = RUN;
            RUN:  if (halt_req)              state_nxt = HALT;
            HALT: begin
                if (trap)                       state_nxt = RUN;
                else if (resume && !halt_req)   state_nxt = RUN;
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        fetch_valid = (state == RUN) && !stall;
        halted      = (state == HALT);
    end

    npc_mux #(
        .RESET_PC (RESET_PC),
        .TRAP_VEC (TRAP_VEC)
    ) u_npc_mux (
        .state       (state),
        .pc_cur      (pc_cur),
        .stall       (stall),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .trap        (trap),
        .pc_next     (pc_next),
        .if_flush    (if_flush),
        .id_flush    (id_flush),
        .redirect    (redirect),
        .misalign    (misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              boot_cnt <= '0;
        else if (state == BOOT)  boot_cnt <= boot_cnt + 1'b1;
        else                     boot_cnt <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) misalign_err <= 1'b0;
        else        misalign_err <= misalign;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              redirect_cnt <= '0;
        else if (redirect && (redirect_cnt != '1)) redirect_cnt <= redirect_cnt + 1'b1;
    end

endmodule
